isa_dma_channel: RTL and testbench
==================================

ISA_DMA_CHANNEL -- requirements
Module: isa_dma_channel

Interface
REQ-001 Parameter CHANNEL, default 1, 8237 channel number (0-3) decoded by this block.
REQ-002 Parameter PAGE_PORT, default 12'h083, page register port for CHANNEL.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 port  in  12  host I/O address; iodin  in  8  host write data; iodout  out  8  host read data (registered).
REQ-006 iowrin/iordin  in  1  host write/read request toggles; iowrout/iordout  out  1  registered copies; request pending when in ^ out.
REQ-007 mem_addr  out  20  {page, current address}; mem_din  in  8  memory read data.
REQ-008 mem_rdout  out  1  memory read request toggle; mem_rdin  in  1  memory completion toggle; mem_din valid when mem_rdin == mem_rdout after mem_rdout toggled.
REQ-009 dma_dout  out  8  byte to peripheral; dma_rdin  out  1  data-ready toggle; dma_rdout  in  1  peripheral consume toggle; byte pending when dma_rdin ^ dma_rdout.
REQ-010 tc  out  1  one-cycle terminal-count pulse.

Function
REQ-011 Registers: base/current address (16b), base/current count (16b), page (8b), mode (autoinit bit 4, transfer type bits 3:2), mask (1b), TC status (1b), byte flip-flop (1b).
REQ-012 Address port = 2*CHANNEL, count port = 2*CHANNEL+1; writes load low byte when flip-flop=0, high byte when 1, into base and current; flip-flop toggles on every access.
REQ-013 Port 0x00A write: if iodin[1:0]==CHANNEL, mask <= iodin[2]; port 0x00B: if iodin[1:0]==CHANNEL, mode <= iodin; port 0x00C write clears flip-flop; PAGE_PORT write loads page.
REQ-014 Reads: address/count ports return current value byte per flip-flop; 0x008 returns TC in bit CHANNEL, other bits 0, and clears TC; PAGE_PORT returns page; all other ports return 8'hFF.
REQ-015 Host access handled in the cycle it is detected pending; iowrout/iordout <= iowrin/iordin every cycle; iodout valid one cycle after detection.
REQ-016 FSM states: IDLE, FETCH, HOLD.
REQ-017 IDLE -> FETCH when mask==0, mode[3:2]==2'b10 (read), and no byte pending; mem_rdout toggles on entry, mem_addr stable throughout FETCH.
REQ-018 FETCH -> HOLD when mem_rdin == mem_rdout: dma_dout <= mem_din, dma_rdin toggles; same cycle current address +1 (wraps FFFF->0000, page unchanged), current count -1.
REQ-019 Count decrement from 0000 to FFFF = terminal count: tc pulses, TC status set; autoinit reloads current from base, else mask <= 1.
REQ-020 HOLD -> IDLE when dma_rdout == dma_rdin; total bytes per block = base count + 1.
REQ-021 Mask set during FETCH/HOLD: in-flight byte completes and is delivered; no further fetch.
REQ-022 Host write to address/count during FETCH: outstanding read keeps latched mem_addr; post-completion increment applies to newly written value.
REQ-023 Host write and transfer update same cycle: host write wins for the written byte.

Reset
REQ-024 reset_n low at clk edge: state IDLE, mask 1, TC 0, flip-flop 0, mode 0, page 0, address/count 0, tc 0, iodout 8'hFF.
REQ-025 Reset: iowrout<=iowrin, iordout<=iordin, mem_rdout<=mem_rdin, dma_rdin<=dma_rdout (no spurious pending toggles); in-flight transfer abandoned.

Structure
REQ-026 Package isa_dma_pkg holds port constants (0x008, 0x00A, 0x00B, 0x00C), mode bit positions, FSM state enum.
REQ-027 Sub-module isa_dma_regs decodes host I/O and holds registers; FSM and counters in top level.

Verification
REQ-028 Program addr 0x1000, count 0x0003, page 0x02, mode 0x49, unmask -> 4 reads at 0x21000-0x21003, 4 bytes delivered, tc once, mask=1 after.
REQ-029 Autoinit (mode 0x59), count 0x0001 -> after 2 bytes tc pulses, address reloads 0x1000, transfers continue.
REQ-030 Address 0xFFFF, count 0x0001 -> reads at page:FFFF then page:0000.
REQ-031 Peripheral withholds dma_rdout toggle 100 cycles -> exactly one mem read outstanding, no second fetch until consumed.
REQ-032 Read 0x008 after TC -> bit CHANNEL=1; second read -> 0x00.
REQ-033 reset_n low mid-FETCH -> IDLE, mask=1, no pending toggles, iodout 8'hFF.

Source files
------------

// File: rtl/isa_dma_pkg.sv
// isa_dma_pkg: shared port map, mode bit positions and channel FSM states
package isa_dma_pkg;
   localparam logic [11:0] PORT_STATUS = 12'h008;
   localparam logic [11:0] PORT_MASK   = 12'h00A;
   localparam logic [11:0] PORT_MODE   = 12'h00B;
   localparam logic [11:0] PORT_CLRFF  = 12'h00C;
   localparam int MODE_AUTO    = 4;
   localparam int MODE_TYPE_HI = 3;
   localparam int MODE_TYPE_LO = 2;
   localparam logic [1:0] XFER_READ = 2'b10;
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
endpackage

// File: rtl/isa_dma_regs.sv
// isa_dma_regs: host I/O decode and the 8237-style channel register file
module isa_dma_regs
   import isa_dma_pkg::*;
#(
   parameter int          CHANNEL   = 1,
   parameter logic [11:0] PAGE_PORT = 12'h083
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] port,
   input  logic [7:0]  iodin,
   input  logic        iowrin,
   input  logic        iordin,
   output logic [7:0]  iodout,
   output logic        iowrout,
   output logic        iordout,
   input  logic        upd,
   input  logic        set_tc,
   input  logic        set_mask,
   input  logic [15:0] nxt_addr,
   input  logic [15:0] nxt_cnt,
   output logic [15:0] base_addr,
   output logic [15:0] cur_addr,
   output logic [15:0] base_cnt,
   output logic [15:0] cur_cnt,
   output logic [7:0]  page,
   output logic        autoinit,
   output logic        xfer_read,
   output logic        mask
);
   localparam logic [11:0] ADDR_PORT = 12'(2 * CHANNEL);
   localparam logic [11:0] CNT_PORT  = 12'(2 * CHANNEL + 1);
   localparam logic [1:0]  CH        = 2'(CHANNEL);
   logic [4:2] mode;
   logic       tc_stat, ff, wr, rd, wa, wc, ra, rc, sel;
   logic [7:0] rd_val;
   assign wr        = iowrin ^ iowrout;
   assign rd        = iordin ^ iordout;
   assign wa        = wr && port == ADDR_PORT;
   assign wc        = wr && port == CNT_PORT;
   assign ra        = rd && port == ADDR_PORT;
   assign rc        = rd && port == CNT_PORT;
   assign sel       = iodin[1:0] == CH;
   assign autoinit  = mode[MODE_AUTO];
   assign xfer_read = mode[MODE_TYPE_HI:MODE_TYPE_LO] == XFER_READ;
   // read data mux for the port currently being read
   always_comb
      rd_val = ra ? (ff ? cur_addr[15:8] : cur_addr[7:0]) :
               rc ? (ff ? cur_cnt[15:8] : cur_cnt[7:0]) :
               port == PORT_STATUS ? 8'(tc_stat) << CHANNEL :
               port == PAGE_PORT ? page : 8'hFF;
   // register updates; host byte writes land after transfer updates so the host wins
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         iowrout   <= iowrin;
         iordout   <= iordin;
         iodout    <= 8'hFF;
         base_addr <= '0;
         cur_addr  <= '0;
         base_cnt  <= '0;
         cur_cnt   <= '0;
         page      <= '0;
         mode      <= '0;
         mask      <= 1'b1;
         tc_stat   <= 1'b0;
         ff        <= 1'b0;
      end else begin
         iowrout <= iowrin;
         iordout <= iordin;
         if (rd) iodout <= rd_val;
         if (upd) begin
            cur_addr <= nxt_addr;
            cur_cnt  <= nxt_cnt;
         end
         if (wa && ff) begin
            base_addr[15:8] <= iodin;
            cur_addr[15:8]  <= iodin;
         end
         if (wa && !ff) begin
            base_addr[7:0] <= iodin;
            cur_addr[7:0]  <= iodin;
         end
         if (wc && ff) begin
            base_cnt[15:8] <= iodin;
            cur_cnt[15:8]  <= iodin;
         end
         if (wc && !ff) begin
            base_cnt[7:0] <= iodin;
            cur_cnt[7:0]  <= iodin;
         end
         if (rd && port == PORT_STATUS) tc_stat <= 1'b0;
         if (set_tc) tc_stat <= 1'b1;
         if (set_mask) mask <= 1'b1;
         if (wr && port == PORT_MASK && sel) mask <= iodin[2];
         if (wr && port == PORT_MODE && sel) mode <= iodin[4:2];
         if (wr && port == PAGE_PORT) page <= iodin;
         if (wr && port == PORT_CLRFF) ff <= 1'b0;
         else if (wa || wc || ra || rc) ff <= ~ff;
      end
   end
endmodule

// File: rtl/isa_dma_channel.sv
// isa_dma_channel: one memory-to-peripheral DMA channel with toggle handshakes
module isa_dma_channel
   import isa_dma_pkg::*;
#(
   parameter int          CHANNEL   = 1,
   parameter logic [11:0] PAGE_PORT = 12'h083
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] port,
   input  logic [7:0]  iodin,
   output logic [7:0]  iodout,
   input  logic        iowrin,
   input  logic        iordin,
   output logic        iowrout,
   output logic        iordout,
   output logic [19:0] mem_addr,
   input  logic [7:0]  mem_din,
   output logic        mem_rdout,
   input  logic        mem_rdin,
   output logic [7:0]  dma_dout,
   output logic        dma_rdin,
   input  logic        dma_rdout,
   output logic        tc
);
   logic [15:0] base_addr, cur_addr, base_cnt, cur_cnt, nxt_addr, nxt_cnt;
   logic [7:0]  page;
   logic        autoinit, xfer_read, mask, upd, tc_hit, reload;
   state_t      state;
   assign upd      = state == FETCH && mem_rdin == mem_rdout;
   assign tc_hit   = upd && cur_cnt == 16'h0000;
   assign reload   = tc_hit && autoinit;
   assign nxt_addr = reload ? base_addr : cur_addr + 16'd1;
   assign nxt_cnt  = reload ? base_cnt : cur_cnt - 16'd1;
   isa_dma_regs #(.CHANNEL(CHANNEL), .PAGE_PORT(PAGE_PORT)) u_regs (
      .clk(clk), .reset_n(reset_n), .port(port), .iodin(iodin), .iowrin(iowrin), .iordin(iordin),
      .iodout(iodout), .iowrout(iowrout), .iordout(iordout),
      .upd(upd), .set_tc(tc_hit), .set_mask(tc_hit && !autoinit), .nxt_addr(nxt_addr), .nxt_cnt(nxt_cnt),
      .base_addr(base_addr), .cur_addr(cur_addr), .base_cnt(base_cnt), .cur_cnt(cur_cnt),
      .page(page), .autoinit(autoinit), .xfer_read(xfer_read), .mask(mask)
   );
   // fetch one byte, hand it to the peripheral, wait for it to be consumed
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         mem_rdout <= mem_rdin;
         dma_rdin  <= dma_rdout;
         mem_addr  <= '0;
         dma_dout  <= '0;
         tc        <= 1'b0;
      end else begin
         tc <= tc_hit;
         if (state == IDLE && !mask && xfer_read && dma_rdin == dma_rdout) begin
            state     <= FETCH;
            mem_rdout <= ~mem_rdout;
            mem_addr  <= {page, cur_addr};
         end
         if (upd) begin
            state    <= HOLD;
            dma_dout <= mem_din;
            dma_rdin <= ~dma_rdin;
         end
         if (state == HOLD && dma_rdout == dma_rdin) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_isa_dma_channel.sv
// tb_isa_dma_channel: randomized-latency bench with a block-level transfer model
module tb_isa_dma_channel;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] port = '0;
   logic [7:0]  iodin = '0;
   logic        iowrin = 1'b0;
   logic        iordin = 1'b0;
   logic [7:0]  mem_din = '0;
   logic        mem_rdin = 1'b0;
   logic        dma_rdout = 1'b0;
   logic [7:0]  iodout, dma_dout;
   logic        iowrout, iordout, mem_rdout, dma_rdin, tc;
   logic [19:0] mem_addr;
   logic [19:0] rd_q[$];
   logic [7:0]  got_q[$];
   int          tc_cnt = 0;
   int          checks = 0;
   int          passed = 0;
   bit          mem_en = 1'b1;
   bit          hold = 1'b0;

   isa_dma_channel #(.CHANNEL(1), .PAGE_PORT(12'h083)) dut (
      .clk(clk), .reset_n(reset_n), .port(port), .iodin(iodin), .iodout(iodout),
      .iowrin(iowrin), .iordin(iordin), .iowrout(iowrout), .iordout(iordout),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_rdout(mem_rdout), .mem_rdin(mem_rdin),
      .dma_dout(dma_dout), .dma_rdin(dma_rdin), .dma_rdout(dma_rdout), .tc(tc)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mdata(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
   endfunction

   // memory: log each request address, answer after a random delay
   initial forever begin
      @(negedge clk);
      if (mem_en && mem_rdout !== mem_rdin) begin
         logic [19:0] a;
         a = mem_addr;
         rd_q.push_back(a);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         mem_din = mdata(a);
         mem_rdin = ~mem_rdin;
      end
   end

   // peripheral: take each offered byte after a random delay unless held off
   initial forever begin
      @(negedge clk);
      if (!hold && dma_rdin !== dma_rdout) begin
         got_q.push_back(dma_dout);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         dma_rdout = ~dma_rdout;
      end
   end

   always @(negedge clk) if (tc === 1'b1) tc_cnt <= tc_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic io_wr(input logic [11:0] p, input logic [7:0] d);
      @(negedge clk);
      port = p;
      iodin = d;
      iowrin = ~iowrin;
      @(negedge clk);
   endtask

   task automatic io_rd(input logic [11:0] p, output logic [7:0] d);
      @(negedge clk);
      port = p;
      iordin = ~iordin;
      @(negedge clk);
      d = iodout;
   endtask

   task automatic prog(input logic [15:0] a, input logic [15:0] c, input logic [7:0] pg, input logic [7:0] md);
      io_wr(12'h00C, 8'h00);
      io_wr(12'h002, a[7:0]);
      io_wr(12'h002, a[15:8]);
      io_wr(12'h003, c[7:0]);
      io_wr(12'h003, c[15:8]);
      io_wr(12'h083, pg);
      io_wr(12'h00B, md);
      io_wr(12'h00A, 8'h01);
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int k;
      k = 0;
      while (got_q.size() < n && k < 4000) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(got_q.size() >= n), 32'd1);
   endtask

   // one non-autoinit block: count+1 consecutive bytes, one tc, then masked
   task automatic run_block(input logic [15:0] a, input logic [15:0] c, input logic [7:0] pg, input string tag);
      int r0, g0, t0;
      logic [7:0] lo, hi;
      logic [19:0] ea;
      r0 = rd_q.size();
      g0 = got_q.size();
      t0 = tc_cnt;
      prog(a, c, pg, 8'h49);
      wait_bytes(g0 + int'(c) + 1, {tag, "_timeout"});
      repeat (20) @(negedge clk);
      check({tag, "_nreads"}, 32'(rd_q.size() - r0), 32'(c) + 1);
      check({tag, "_nbytes"}, 32'(got_q.size() - g0), 32'(c) + 1);
      for (int i = 0; i <= int'(c); i++) begin
         ea = {pg, 16'(a + 16'(i))};
         check($sformatf("%s_addr%0d", tag, i), 32'(rd_q[r0 + i]), 32'(ea));
         check($sformatf("%s_data%0d", tag, i), 32'(got_q[g0 + i]), 32'(mdata(ea)));
      end
      check({tag, "_tc"}, 32'(tc_cnt - t0), 32'd1);
      io_rd(12'h002, lo);
      io_rd(12'h002, hi);
      check({tag, "_curaddr"}, 32'({hi, lo}), 32'(16'(a + c + 16'd1)));
      io_rd(12'h003, lo);
      io_rd(12'h003, hi);
      check({tag, "_curcnt"}, 32'({hi, lo}), 32'h0000FFFF);
   endtask

   initial begin
      logic [7:0] d, lo, hi;
      int r0, g0, t0, n, k;
      logic mr;
      repeat (3) @(negedge clk);
      check("rst_iodout", 32'(iodout), 32'hFF);
      check("rst_tc", 32'(tc), 32'd0);
      check("rst_memaddr", 32'(mem_addr), 32'd0);
      check("rst_memtog", 32'(mem_rdout ^ mem_rdin), 32'd0);
      check("rst_dmatog", 32'(dma_rdin ^ dma_rdout), 32'd0);
      reset_n = 1'b1;
      io_rd(12'h002, lo);
      io_rd(12'h002, hi);
      check("rst_addr", 32'({hi, lo}), 32'd0);
      io_rd(12'h008, d);
      check("rst_status", 32'(d), 32'd0);
      io_rd(12'h083, d);
      check("rst_page", 32'(d), 32'd0);
      io_rd(12'h123, d);
      check("unmapped_port", 32'(d), 32'hFF);

      run_block(16'h1000, 16'h0003, 8'h02, "basic");
      io_rd(12'h008, d);
      check("status_tc", 32'(d), 32'h02);
      io_rd(12'h008, d);
      check("status_clr", 32'(d), 32'h00);

      run_block(16'hFFFF, 16'h0001, 8'h07, "wrap");
      repeat (3) run_block(16'($urandom), 16'($urandom_range(0, 5)), 8'($urandom), "rnd");

      r0 = rd_q.size();
      g0 = got_q.size();
      t0 = tc_cnt;
      prog(16'h1000, 16'h0001, 8'h05, 8'h59);
      wait_bytes(g0 + 5, "auto_timeout");
      io_wr(12'h00A, 8'h05);
      repeat (30) @(negedge clk);
      n = rd_q.size() - r0;
      repeat (30) @(negedge clk);
      check("auto_stop", 32'(rd_q.size() - r0), 32'(n));
      check("auto_inflight", 32'(got_q.size() - g0), 32'(n));
      for (int i = 0; i < n; i++)
         check($sformatf("auto_addr%0d", i), 32'(rd_q[r0 + i]), 32'h51000 + 32'(i % 2));
      check("auto_tc", 32'(tc_cnt - t0), 32'(n / 2));
      io_rd(12'h002, lo);
      io_rd(12'h002, hi);
      check("auto_reload", 32'({hi, lo}), 32'h1000 + 32'(n % 2));

      hold = 1'b1;
      r0 = rd_q.size();
      g0 = got_q.size();
      prog(16'h2000, 16'h0002, 8'h00, 8'h49);
      repeat (100) @(negedge clk);
      check("hold_reads", 32'(rd_q.size() - r0), 32'd1);
      check("hold_pending", 32'(dma_rdin ^ dma_rdout), 32'd1);
      check("hold_dout", 32'(dma_dout), 32'(mdata(20'h02000)));
      hold = 1'b0;
      wait_bytes(g0 + 3, "hold_timeout");
      repeat (20) @(negedge clk);
      check("hold_total", 32'(rd_q.size() - r0), 32'd3);
      check("hold_last", 32'(got_q[g0 + 2]), 32'(mdata(20'h02002)));

      mem_en = 1'b0;
      prog(16'h3000, 16'h0005, 8'h01, 8'h49);
      k = 0;
      while (mem_rdout === mem_rdin && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("fetch_started", 32'(mem_rdout ^ mem_rdin), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("mrst_memtog", 32'(mem_rdout ^ mem_rdin), 32'd0);
      check("mrst_dmatog", 32'(dma_rdin ^ dma_rdout), 32'd0);
      check("mrst_iodout", 32'(iodout), 32'hFF);
      mem_en = 1'b1;
      r0 = rd_q.size();
      io_wr(12'h00B, 8'h49);
      mr = mem_rdout;
      repeat (30) @(negedge clk);
      check("mrst_masked", 32'(mem_rdout), 32'(mr));
      check("mrst_noreads", 32'(rd_q.size() - r0), 32'd0);
      io_rd(12'h002, lo);
      check("mrst_addr", 32'(lo), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
